// File: rtl/i_cache_ctrl.sv
// Direct-mapped instruction cache controller sitting between the fetch stage and a
// 128-bit block-read instruction memory. Hits return a word combinationally; misses
// stall the CPU, fetch the whole block, fill the line and let the fetch replay.
// Optional hit/miss performance counters are enabled with ICACHE_PERF_CNT_EN.
module i_cache_ctrl #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned INDEX_W   = 3,
  parameter int unsigned TAG_W     = 25
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC_ADDR,
  input  logic         PC_VALID,
  output logic [31:0]  INSTR,
  output logic         CPU_BUSYWAIT,
  output logic         MEM_READ_EN,
  output logic [27:0]  MEM_READ_ADDR,
  input  logic [127:0] MEM_READ_DATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];
  logic [27:0]          miss_addr_q, miss_addr_d;

  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [1:0]         pc_offset;
  logic [127:0]       line_data;
  logic               hit;
  logic               miss;
  logic               fill_we;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;

  // Byte-within-word bits carry no information for word-aligned fetches.
  logic unused_pc_byte;
  assign unused_pc_byte = ^PC_ADDR[1:0];

  assign pc_offset  = PC_ADDR[3:2];
  assign pc_index   = PC_ADDR[4+INDEX_W-1:4];
  assign pc_tag     = PC_ADDR[31:4+INDEX_W];
  assign fill_index = miss_addr_q[INDEX_W-1:0];
  assign fill_tag   = miss_addr_q[27:INDEX_W];

  assign line_data = data_q[pc_index];
  assign hit       = PC_VALID & valid_q[pc_index] & (tag_q[pc_index] == pc_tag);
  assign miss      = PC_VALID & ~hit;

  assign MEM_READ_ADDR = miss_addr_q;

  // Word select from the indexed line; only meaningful on a hit.
  always_comb begin
    INSTR = line_data[31:0];
    unique case (pc_offset)
      2'd0: INSTR = line_data[31:0];
      2'd1: INSTR = line_data[63:32];
      2'd2: INSTR = line_data[95:64];
      2'd3: INSTR = line_data[127:96];
      default: INSTR = line_data[31:0];
    endcase
  end

  // Next-state, stall and memory-request decode.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    CPU_BUSYWAIT = 1'b0;
    MEM_READ_EN  = 1'b0;
    fill_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        CPU_BUSYWAIT = miss;
        if (miss) begin
          miss_addr_d = PC_ADDR[31:4];
          state_d     = StMemRead;
        end
      end
      StMemRead: begin
        MEM_READ_EN  = 1'b1;
        CPU_BUSYWAIT = 1'b1;
        // First cycle always reads busy, so data is never taken before the memory is ready.
        if (!MEM_BUSYWAIT) begin
          fill_we = 1'b1;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        CPU_BUSYWAIT = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, miss address and valid bits; reset aborts any fill in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_we) begin
        valid_q[fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; filled from the latched miss address, never the live PC.
  always_ff @(posedge CLK) begin
    if (fill_we && !RESET) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= MEM_READ_DATA;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Hit/miss event counters; free-running and wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else if (state_q == StIdle) begin
      if (hit) begin
        HIT_COUNT <= HIT_COUNT + 32'd1;
      end
      if (miss) begin
        MISS_COUNT <= MISS_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_cache_ctrl.sv
// Self-checking bench for i_cache_ctrl with a fixed-latency block memory model.
module tb_i_cache_ctrl;

  localparam int LAT     = 3;              // busy cycles of the memory model per request
  localparam int PEN     = 1 + (LAT + 1) + 1;
  localparam int TIMEOUT = 100;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC_ADDR;
  logic         PC_VALID;
  logic [31:0]  INSTR;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ_EN;
  logic [27:0]  MEM_READ_ADDR;
  logic [127:0] MEM_READ_DATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  i_cache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC_ADDR       (PC_ADDR),
    .PC_VALID      (PC_VALID),
    .INSTR         (INSTR),
    .CPU_BUSYWAIT  (CPU_BUSYWAIT),
    .MEM_READ_EN   (MEM_READ_EN),
    .MEM_READ_ADDR (MEM_READ_ADDR),
    .MEM_READ_DATA (MEM_READ_DATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .HIT_COUNT     (hit_count),
    .MISS_COUNT    (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory contents: distinct word for every (block, word) pair.
  function automatic logic [31:0] mem_word(input logic [27:0] a, input logic [1:0] k);
    logic [31:0] key;
    key = {a, 2'b00, k};
    return (key * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory model: busy is combinational on READ_EN for LAT cycles, then ready.
  logic [7:0] mem_cnt = 8'd0;
  always @(posedge CLK) mem_cnt <= MEM_READ_EN ? mem_cnt + 8'd1 : 8'd0;
  assign MEM_BUSYWAIT = MEM_READ_EN && (mem_cnt < LAT);
  always_comb begin
    MEM_READ_DATA = {mem_word(MEM_READ_ADDR, 2'd3), mem_word(MEM_READ_ADDR, 2'd2),
                     mem_word(MEM_READ_ADDR, 2'd1), mem_word(MEM_READ_ADDR, 2'd0)};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Issue one fetch and wait for it to complete; checks stall length, request, data.
  task automatic fetch(input logic [31:0] pc, input int exp_stall, input string name);
    int stall;
    logic saw_req;
    logic [31:0] exp;
    exp_q.push_back(mem_word(pc[31:4], pc[3:2]));
    PC_ADDR  = pc;
    PC_VALID = 1'b1;
    stall    = 0;
    saw_req  = 1'b0;
    @(negedge CLK);
    while (CPU_BUSYWAIT === 1'b1 && stall < TIMEOUT) begin
      if (MEM_READ_EN === 1'b1 && !saw_req) begin
        saw_req = 1'b1;
        n_checks++;
        if (MEM_READ_ADDR !== pc[31:4]) begin
          n_fail++;
          $display("FAIL %s req_addr: got %h required %h", name, MEM_READ_ADDR, pc[31:4]);
        end
      end
      stall++;
      @(negedge CLK);
    end
    n_checks++;
    if (stall !== exp_stall) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d required %0d", name, stall, exp_stall);
    end
    n_checks++;
    if (saw_req !== (exp_stall != 0)) begin
      n_fail++;
      $display("FAIL %s mem_request: got %b required %b", name, saw_req, exp_stall != 0);
    end
    n_checks++;
    if (MEM_READ_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL %s read_en_on_hit: got %b required 0", name, MEM_READ_EN);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (INSTR !== exp) begin
      n_fail++;
      $display("FAIL %s instr: got %h required %h", name, INSTR, exp);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    PC_VALID = 1'b0;
    PC_ADDR  = 32'h0;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (CPU_BUSYWAIT !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_idle: got %b required 0", CPU_BUSYWAIT);
    end
    n_checks++;
    if (MEM_READ_EN !== 1'b0 || MEM_READ_ADDR !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_mem_if: got en=%b addr=%h required en=0 addr=0000000",
               MEM_READ_EN, MEM_READ_ADDR);
    end
    PC_VALID = 1'b1;
    #1;
    n_checks++;
    if (CPU_BUSYWAIT !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cold_miss_busy: got %b required 1", CPU_BUSYWAIT);
    end
`ifdef ICACHE_PERF_CNT_EN
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d required 0 0", hit_count, miss_count);
    end
`endif
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    PC_VALID = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0000, PEN, "cold_miss");
  endtask

  task automatic test_spatial_hits();
    fetch(32'h0000_0004, 0, "hit_w1");
    fetch(32'h0000_0008, 0, "hit_w2");
    fetch(32'h0000_000C, 0, "hit_w3");
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0080, PEN, "conflict_new");
    fetch(32'h0000_0000, PEN, "conflict_back");
    fetch(32'h0000_0004, 0,   "conflict_hit");
  endtask

  task automatic test_reset_mid_fill();
    PC_ADDR  = 32'h0000_0010;
    PC_VALID = 1'b1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    n_checks++;
    if (MEM_READ_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL midfill_in_read: got %b required 1", MEM_READ_EN);
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    PC_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (MEM_READ_EN !== 1'b0 || MEM_READ_ADDR !== 28'h0 || CPU_BUSYWAIT !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_abort: got en=%b addr=%h busy=%b required en=0 addr=0000000 busy=0",
               MEM_READ_EN, MEM_READ_ADDR, CPU_BUSYWAIT);
    end
    @(posedge CLK);
    #1;
    fetch(32'h0000_0010, PEN, "midfill_refetch");
    fetch(32'h0000_0000, PEN, "midfill_line0_cleared");
  endtask

  task automatic test_idle_and_pc_change();
    int guard;
    for (int i = 0; i < 4; i++) begin
      PC_ADDR  = $urandom;
      PC_VALID = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (CPU_BUSYWAIT !== 1'b0 || MEM_READ_EN !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_request: got busy=%b en=%b required 0 0",
                 CPU_BUSYWAIT, MEM_READ_EN);
      end
      @(posedge CLK);
      #1;
    end
    PC_ADDR  = 32'h0000_0020;
    PC_VALID = 1'b1;
    @(posedge CLK);
    #1;
    PC_ADDR = 32'h0000_0044;
    guard   = 0;
    @(negedge CLK);
    while (MEM_READ_EN === 1'b1 && guard < TIMEOUT) begin
      n_checks++;
      if (MEM_READ_ADDR !== 28'h000_0002) begin
        n_fail++;
        $display("FAIL pc_change_addr: got %h required 0000002", MEM_READ_ADDR);
      end
      guard++;
      @(negedge CLK);
    end
    n_checks++;
    if (guard !== LAT + 1 || CPU_BUSYWAIT !== 1'b1) begin
      n_fail++;
      $display("FAIL pc_change_read_len: got %0d busy=%b required %0d busy=1",
               guard, CPU_BUSYWAIT, LAT + 1);
    end
    PC_ADDR = 32'h0000_0020;
    @(posedge CLK);
    #1;
    fetch(32'h0000_0020, 0,   "pc_change_filled");
    fetch(32'h0000_0044, PEN, "pc_change_not_filled");
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    RESET    = 1'b1;
    PC_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    fetch(32'h0000_0000, PEN, "perf_cold");
    fetch(32'h0000_0004, 0,   "perf_h1");
    fetch(32'h0000_0008, 0,   "perf_h2");
    fetch(32'h0000_000C, 0,   "perf_h3");
    PC_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (hit_count !== 32'd4 || miss_count !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_counts: got hit=%0d miss=%0d required 4 1", hit_count, miss_count);
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got hit=%0d miss=%0d required 0 0", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    RESET    = 1'b1;
    PC_VALID = 1'b0;
    PC_ADDR  = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_cold_miss();
    test_spatial_hits();
    test_conflict();
    test_reset_mid_fill();
    test_idle_and_pc_change();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
